// File: rtl/crc16_encoder_if.sv
// Handshake/bus bundle between a message source and the CRC-16 encoder.
// The source (master) drives the start strobe and message word; the encoder
// (slave) returns busy, the one-cycle valid pulse and the codeword.
interface crc16_encoder_if #(
  parameter int DATA_W = 16
);
  logic                sync;
  logic [DATA_W-1:0]   Data;
  logic                busy;
  logic                valid;
  logic [DATA_W+15:0]  code;

  modport master (
    output sync,
    output Data,
    input  busy,
    input  valid,
    input  code
  );

  modport slave (
    input  sync,
    input  Data,
    output busy,
    output valid,
    output code
  );
endinterface

// File: rtl/crc16_encoder.sv
// Bit-serial CRC-16 encoder. A message latched on sync is shifted MSB-first
// through a 16-bit LFSR (normal form, no reflection, no final XOR), and the
// systematic codeword {message, crc} is presented with a one-cycle valid pulse.
module crc16_encoder #(
  parameter int          DATA_W = 16,
  parameter logic [15:0] POLY   = 16'h8005,
  parameter logic [15:0] INIT   = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  crc16_encoder_if.slave   bus
);

  // Bit counter is wide enough to reach DATA_W-1, at least one bit.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   msg_reg;
  logic [DATA_W-1:0]   sh_reg;
  logic [15:0]         crc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                fb;
  logic [15:0]         crc_next;

  // One LFSR step: feedback is the CRC MSB xored with the next message bit.
  always_comb begin
    fb       = crc_reg[15] ^ sh_reg[DATA_W-1];
    crc_next = {crc_reg[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      msg_reg   <= '0;
      sh_reg    <= '0;
      crc_reg   <= '0;
      cnt_reg   <= '0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.code  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // valid is a single-cycle pulse, so it always drops in IDLE;
          // a start in the same cycle as valid is still accepted.
          bus.valid <= 1'b0;
          if (bus.sync) begin
            msg_reg   <= bus.Data;
            sh_reg    <= bus.Data;
            crc_reg   <= INIT;
            cnt_reg   <= '0;
            bus.busy  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          // sync and Data are deliberately not looked at while shifting.
          bus.valid <= 1'b0;
          crc_reg   <= crc_next;
          sh_reg    <= sh_reg << 1;
          if (cnt_reg == CNT_LAST) begin
            // Counter holds at its last value; it is reloaded on the next start.
            bus.code  <= {msg_reg, crc_next};
            bus.valid <= 1'b1;
            bus.busy  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_encoder.sv
// Self-checking bench for crc16_encoder (DATA_W=16). Expected codewords come
// from a polynomial long-division reference and are queued with the cycle at
// which valid must appear; a monitor pops and compares on every valid pulse.
module tb_crc16_encoder;

  localparam int          DW   = 16;
  localparam logic [15:0] POLY = 16'h8005;

  typedef struct {
    logic [31:0] code;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t e;
  logic prev_valid;

  crc16_encoder_if #(.DATA_W(DW)) bus ();

  crc16_encoder #(.DATA_W(DW), .POLY(POLY), .INIT(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Remainder of m(x)*x^16 divided by x^16+POLY, by schoolbook long division.
  function automatic logic [31:0] ref_code(input logic [15:0] m);
    logic [31:0] r;
    r = {m, 16'h0000};
    for (int i = 31; i >= 16; i--) begin
      if (r[i]) r[i -: 17] = r[i -: 17] ^ {1'b1, POLY};
    end
    return {m, r[15:0]};
  endfunction

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && bus.valid) begin
      check("valid_width", {63'd0, prev_valid}, 64'd0);
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check("code", {32'd0, bus.code}, {32'd0, e.code});
        check("latency", 64'(cyc), 64'(e.cyc));
        $display("txn code=%08h exp=%08h cyc=%0d", bus.code, e.code, cyc);
      end
    end
    prev_valid <= bus.valid;
  end

  // Wait (bounded) for the encoder to be idle, then issue one start strobe.
  task automatic send(input logic [15:0] d, input bit accept);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {63'd0, (n < 100)}, 64'd1);
    bus.sync = 1'b1;
    bus.Data = d;
    if (accept) sb.push_back('{code: ref_code(d), cyc: cyc + 1 + DW});
    @(negedge clk);
    bus.sync = 1'b0;
    bus.Data = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  logic [15:0] vec[8];

  initial begin
    int bc;
    int n0;
    checks     = 0;
    failures   = 0;
    prev_valid = 1'b0;
    reset      = 1'b0;
    bus.sync   = 1'b1;
    bus.Data   = 16'hA5A5;

    // Reset held with sync asserted: everything stays cleared.
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_valid", {63'd0, bus.valid}, 64'd0);
      check("rst_code", {32'd0, bus.code}, 64'd0);
    end
    bus.sync = 1'b0;
    reset    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", {63'd0, bus.busy}, 64'd0);
      check("idle_code", {32'd0, bus.code}, 64'd0);
    end

    // Directed and random messages; busy must be high for exactly DW cycles.
    vec[0] = 16'h0001; vec[1] = 16'h0002; vec[2] = 16'h8000; vec[3] = 16'hFFFF;
    vec[4] = 16'h0000; vec[5] = 16'($urandom); vec[6] = 16'($urandom); vec[7] = 16'h1234;
    for (int v = 0; v < 8; v++) begin
      send(vec[v], 1'b1);
      bc = 0;
      for (int k = 0; k < 40; k++) begin
        if (bus.valid) break;
        if (bus.busy) bc++;
        @(negedge clk);
      end
      check("valid_seen", {63'd0, bus.valid}, 64'd1);
      check("busy_cycles", 64'(bc), 64'(DW));
      @(negedge clk);
    end
    drain();

    // Busy-ignore: a second strobe during shifting must not restart or queue.
    send(16'h0001, 1'b1);
    repeat (4) @(negedge clk);
    bus.sync = 1'b1;
    bus.Data = 16'hFFFF;
    @(negedge clk);
    bus.sync = 1'b0;
    repeat (30) @(negedge clk);
    drain();

    // Back-to-back with sync held high; Data changes during shifting.
    n0 = cyc + 1;
    bus.sync = 1'b1;
    bus.Data = 16'h0002;
    sb.push_back('{code: ref_code(16'h0002), cyc: n0 + DW});
    @(negedge clk);
    bus.Data = 16'h8000;
    sb.push_back('{code: ref_code(16'h8000), cyc: n0 + DW + 1 + DW});
    repeat (DW + 1) @(negedge clk);
    bus.sync = 1'b0;
    drain();

    // Reset mid-encode: abort at once, code cleared, no valid pulse.
    send(16'h5A5A, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_valid", {63'd0, bus.valid}, 64'd0);
    check("abort_code", {32'd0, bus.code}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_code_hold", {32'd0, bus.code}, 64'd0);
    send(16'hFFFF, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc16_encoder.md
Name: crc16_encoder

Overview:
Bit-serial CRC-16 encoder, the transmit-side counterpart of the CRC16 decoder. It accepts a DATA_W-bit message on a sync strobe and shifts it MSB-first through a 16-bit LFSR. It then emits the systematic codeword {message, crc}, which has the same layout the decoder consumes (DATA_W=16 gives a 32-bit codeword). It sits in front of the channel or error-injection stage in the ECC datapath.

Parameters:
DATA_W, 16, message width in bits; legal range 1..64.
POLY, 16'h8005, generator polynomial, x^16 implicit, normal (non-reflected) form.
INIT, 16'h0000, LFSR preset loaded at start of every message.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
sync  input  1  start strobe; sampled only in IDLE; latches Data
Data  input  DATA_W  message word, valid in the cycle sync is sampled
busy  output  1  high while a message is being encoded
valid  output  1  one-cycle pulse: code holds a new codeword
code  output  DATA_W+16  codeword {message, crc[15:0]}; message in MSBs

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0; valid=0; code=0; LFSR=0; bit counter=0; message register=0. All registers stay cleared while reset=0.
- States: IDLE, SHIFT. No other states.
- IDLE and sync=1 at edge N:
  - msg_reg<=Data, sh_reg<=Data, crc<=INIT, cnt<=0.
  - busy<=1, state<=SHIFT.
- IDLE and sync=0: hold all registers; valid<=0.
- SHIFT, each edge:
  - fb = crc[15] ^ sh_reg[DATA_W-1].
  - crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - sh_reg <= sh_reg<<1; cnt<=cnt+1.
- Last shift (cnt==DATA_W-1) at edge N+DATA_W:
  - code<={msg_reg, next crc}; valid<=1; busy<=0; state<=IDLE.
- Latency: sync sampled at edge N → valid high during the cycle after edge N+DATA_W (N+16 for the default).
- valid is high for exactly one cycle. code holds its value until the next completion or reset.
- Counter width is clog2(DATA_W) bits, minimum 1; it never wraps past DATA_W-1.
- sync while busy=1 is ignored: no restart, no queuing, Data not sampled.
- sync in the cycle valid=1 is accepted (state is IDLE): a new encode starts. valid still drops next cycle. Back-to-back throughput is one message per DATA_W+1 cycles.
- Data changing during SHIFT has no effect.
- Reset asserted mid-SHIFT aborts the encode immediately. No valid pulse is produced, and code returns to 0.
- Arithmetic is pure GF(2): no final XOR, no bit reflection.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with sync=1 → busy=0, valid=0, code=0 throughout; release, sync=0 → outputs remain 0.
- Directed vectors, one message each, checking the single valid pulse exactly 16 cycles after the sync edge and busy high for cycles N+1..N+16:
  - Data=16'h0001 → code=32'h00018005
  - Data=16'h0002 → code=32'h0002800F
  - Data=16'h8000 → code=32'h80008009
  - Data=16'hFFFF → code=32'hFFFF800D
  - Data=16'h0000 → code=32'h00000000
- Decoder loopback: feed 32'hFFFF800D with bit 16 flipped (32'hFFFE800D) to CRC16_decoder → decoder correct_code=32'hFFFF800D.
- Busy-ignore: sync=1 with Data=16'h0001, then re-pulse sync with Data=16'hFFFF at cycle N+5 → single valid, code=32'h00018005, no second valid.
- Back-to-back: sync held high continuously, Data=16'h0002 then 16'h8000 → valid pulses 17 cycles apart, code 32'h0002800F then 32'h80008009.
- Reset mid-operation: drive reset=0 at cycle N+8 of an encode → busy=0, code=0 at once, no valid pulse; the next sync with Data=16'hFFFF → 32'hFFFF800D.
